// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        COUNT_HIGH,
        STABLE_HIGH,
        COUNT_LOW
    } debounce_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button: polarity fix, synchronizer chain, debounce FSM, registered pulses.
// Optional sticky press flag when BUTTON_CONDITIONER_STICKY_EN is defined.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = MIN_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          INPUT_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic notReset,
    input  logic rawButton,
    input  logic clearSticky,
    output logic debounced,
    output logic pressPulse,
    output logic releasePulse,
    output logic stickyPress
);

    localparam int unsigned STAGES =
        (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [STAGES-1:0] sync_q;
    logic              in_level;
    logic              syncd;

    debounce_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              deb_q, deb_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;

    assign in_level = INPUT_ACTIVE_LOW ? ~rawButton : rawButton;
    assign syncd    = sync_q[STAGES-1];

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_level};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (syncd) begin
                    state_d = COUNT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT_HIGH: begin
                if (!syncd) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    deb_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!syncd) begin
                    state_d = COUNT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT_LOW: begin
                if (syncd) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    deb_d   = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign debounced    = deb_q;
    assign pressPulse   = press_q;
    assign releasePulse = rel_q;

`ifdef BUTTON_CONDITIONER_STICKY_EN
    logic sticky_q;

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= press_q | (sticky_q & ~clearSticky);
        end
    end

    assign stickyPress = sticky_q;
`else
    logic unused_clear_sticky;

    assign unused_clear_sticky = clearSticky;
    assign stickyPress         = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Board-level pushbutton conditioner: one independent debounce channel per button.
// Define BUTTON_CONDITIONER_STICKY_EN to enable the latched stickyPress flags.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS      = 4,
    parameter int unsigned SYNC_STAGES      = MIN_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          INPUT_ACTIVE_LOW = 1'b1
) (
    input  logic                   clock,
    input  logic                   notReset,
    input  logic [NUM_BUTTONS-1:0] rawButton,
    output logic [NUM_BUTTONS-1:0] debounced,
    output logic [NUM_BUTTONS-1:0] pressPulse,
    output logic [NUM_BUTTONS-1:0] releasePulse,
    output logic [NUM_BUTTONS-1:0] stickyPress,
    input  logic [NUM_BUTTONS-1:0] clearSticky
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        debounce_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW)
        ) u_channel (
            .clock        (clock),
            .notReset     (notReset),
            .rawButton    (rawButton[i]),
            .clearSticky  (clearSticky[i]),
            .debounced    (debounced[i]),
            .pressPulse   (pressPulse[i]),
            .releasePulse (releasePulse[i]),
            .stickyPress  (stickyPress[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: run-length reference model feeds an
// expected-event queue that a negedge monitor drains against the DUT pulses.
module tb_button_conditioner;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic         clock = 1'b0;
    logic         notReset = 1'b0;
    logic [N-1:0] rawButton = '1;
    logic [N-1:0] clearSticky = '0;
    logic [N-1:0] debounced, pressPulse, releasePulse, stickyPress;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int ch;
        bit is_press;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state.
    logic [N-1:0] pipe [SYNC];
    logic [N-1:0] deb_m = '0;
    logic [N-1:0] sticky_m = '0;
    logic [N-1:0] press_prev = '0;
    int           run [N];

    button_conditioner #(
        .NUM_BUTTONS      (N),
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DC),
        .INPUT_ACTIVE_LOW (1'b1)
    ) dut (
        .clock        (clock),
        .notReset     (notReset),
        .rawButton    (rawButton),
        .debounced    (debounced),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .stickyPress  (stickyPress),
        .clearSticky  (clearSticky)
    );

    always #5 clock = ~clock;

    // A change is accepted once the synchronized level has disagreed with the
    // accepted level for DC+1 consecutive cycles.
    always @(posedge clock) begin
        logic [N-1:0] sy;
        logic [N-1:0] new_press;
        cyc++;
        if (!notReset) begin
            for (int k = 0; k < SYNC; k++) pipe[k] = '0;
            for (int c = 0; c < N; c++) run[c] = 0;
            deb_m      = '0;
            sticky_m   = '0;
            press_prev = '0;
        end else begin
            sy        = pipe[SYNC-1];
            new_press = '0;
            sticky_m  = press_prev | (sticky_m & ~clearSticky);
            for (int c = 0; c < N; c++) begin
                if (sy[c] != deb_m[c]) begin
                    run[c]++;
                    if (run[c] == DC + 1) begin
                        deb_m[c] = sy[c];
                        run[c]   = 0;
                        exp_q.push_back('{cyc: cyc, ch: c, is_press: sy[c]});
                        new_press[c] = sy[c];
                    end
                end else begin
                    run[c] = 0;
                end
            end
            press_prev = new_press;
            for (int k = SYNC - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = ~rawButton;
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] exp_sticky;
        if (!notReset) begin
            exp_q.delete();
            total++;
            if ((debounced | pressPulse | releasePulse | stickyPress) !== '0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got deb=%b prs=%b rel=%b stk=%b want all 0",
                         cyc, debounced, pressPulse, releasePulse, stickyPress);
            end
        end else begin
            total++;
            if (debounced !== deb_m) begin
                bad++;
                $display("FAIL debounced cyc=%0d got %b want %b", cyc, debounced, deb_m);
            end
            for (int c = 0; c < N; c++) begin
                for (int kind = 1; kind >= 0; kind--) begin
                    if ((kind == 1) ? pressPulse[c] : releasePulse[c]) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL pulse cyc=%0d ch=%0d got press=%0d want no pulse",
                                     cyc, c, kind);
                        end else if (exp_q[0].cyc != cyc || exp_q[0].ch != c ||
                                     int'(exp_q[0].is_press) != kind) begin
                            bad++;
                            $display("FAIL pulse cyc=%0d ch=%0d got press=%0d want cyc=%0d ch=%0d press=%0d",
                                     cyc, c, kind, exp_q[0].cyc, exp_q[0].ch, exp_q[0].is_press);
                            void'(exp_q.pop_front());
                        end else begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_pulse cyc=%0d got none want ch=%0d press=%0d at cyc=%0d",
                         cyc, exp_q[0].ch, exp_q[0].is_press, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
`ifdef BUTTON_CONDITIONER_STICKY_EN
            exp_sticky = sticky_m;
`else
            exp_sticky = '0;
`endif
            total++;
            if (stickyPress !== exp_sticky) begin
                bad++;
                $display("FAIL sticky cyc=%0d got %b want %b", cyc, stickyPress, exp_sticky);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        int  t0;
        bit  seen;

        for (int k = 0; k < SYNC; k++) pipe[k] = '0;
        for (int c = 0; c < N; c++) run[c] = 0;

        // Reset with all buttons released, then idle.
        tick(3);
        notReset = 1'b1;
        tick(20);

        // Clean press on button 0 with explicit latency check.
        rawButton[0] = 1'b0;
        t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (pressPulse[0]) seen = 1'b1;
        end
        total++;
        if (!seen || (cyc - (t0 + 1)) != SYNC + DC) begin
            bad++;
            $display("FAIL press_latency got seen=%0d latency=%0d want latency=%0d",
                     seen, cyc - (t0 + 1), SYNC + DC);
        end
        tick(8);

        // Clear the sticky flag alone.
        clearSticky[0] = 1'b1;
        tick(1);
        clearSticky[0] = 1'b0;
        tick(4);

        // Bounce on button 1, then held pressed.
        for (int k = 0; k < 6; k++) begin
            rawButton[1] = ~rawButton[1];
            tick(2);
        end
        rawButton[1] = 1'b0;
        tick(12);

        // Buttons 2 and 3 pressed, then released together.
        rawButton[3:2] = 2'b00;
        tick(12);
        rawButton[3:2] = 2'b11;
        tick(12);

        // Reset mid-count on button 0.
        rawButton = '1;
        tick(12);
        rawButton[0] = 1'b0;
        tick(3);
        notReset = 1'b0;
        tick(2);
        notReset = 1'b1;
        tick(12);

        // New press while clearSticky is asserted in the pulse cycle.
        rawButton[0] = 1'b1;
        tick(12);
        rawButton[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick(1);
            if (pressPulse[0]) begin
                clearSticky[0] = 1'b1;
                seen = 1'b1;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL second_press_timeout got no pressPulse[0] want one within 20 cycles");
        end
        tick(1);
        clearSticky[0] = 1'b0;
`ifdef BUTTON_CONDITIONER_STICKY_EN
        total++;
        if (stickyPress[0] !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set_wins got %b want 1", stickyPress[0]);
        end
`endif
        tick(4);

        // Randomized phase with one asynchronous reset pulse.
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 4) == 0) rawButton[b] = ~rawButton[b];
            end
            clearSticky = N'($urandom & $urandom & $urandom);
            if (k == 300) notReset = 1'b0;
            if (k == 302) notReset = 1'b1;
            tick(1);
        end

        rawButton   = '1;
        clearSticky = '0;
        tick(20);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending events want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
